spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_reg_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI-to-register bridge.
//   spi_state_e  : frame FSM states
//   rd_flag_pos  : bit position of the read flag inside the ADDR_W-bit
//                  address word (the first bit shifted in, i.e. the MSB)
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DUMMY = 3'd2,
    ST_DATA  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  // The read flag leads the address phase, so it lands in the MSB.
  function automatic int rd_flag_pos(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser plus edge detector for one asynchronous SPI input.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset (chain returns to IDLE_VAL)
//   din_i  : asynchronous input pin
//   lvl_o  : synchronised level
//   rise_o : one-cycle pulse on a synchronised 0->1 transition
//   fall_o : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave to parallel register-bus bridge, single sys_clk domain.
// Frame: ADDR_W address bits (MSB = read flag), DUMMY_CYCLES idle clocks,
// then DATA_W data bits, all MSB first.
// Optional feature: define SPI_REG_BRIDGE_BURST_EN to keep streaming words
// at consecutive addresses while CS stays low.
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   spi_clk, spi_cs_n,
//   spi_mosi, spi_miso   : SPI slave pins
//   reg_addr, reg_wdata,
//   reg_we, reg_re       : register bus request (one-cycle strobes)
//   reg_rdata            : read data, valid one cycle after reg_re
//   frame_err            : one-cycle pulse when CS rises mid-word
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-2:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int              CNT_W      = 6;
  localparam int              RD_POS     = rd_flag_pos(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-2:0] ADDR_ONE  = (ADDR_W-1)'(1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .clk_i(sys_clk), .rst_i(sys_rst), .din_i(spi_clk),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clk_i(sys_clk), .rst_i(sys_rst), .din_i(spi_cs_n),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
    .clk_i(sys_clk), .rst_i(sys_rst), .din_i(spi_mosi),
    .lvl_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-2:0]   addr_sh_q, addr_sh_d;
  logic [DATA_W-2:0]   wr_sh_q, wr_sh_d;
  logic [DATA_W-1:0]   rd_sh_q, rd_sh_d;
  logic                rd_q, rd_d;
  logic                words_q, words_d;
  logic [ADDR_W-2:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_re_q, reg_re_d;
  logic                re_dly_q, re_dly_d;
  logic                miso_q, miso_d;
  logic                ferr_q, ferr_d;
  logic                armed_q, armed_d;
  logic [2:0]          arm_cnt_q, arm_cnt_d;
  logic [ADDR_W-1:0]   addr_full;
  logic [DATA_W-1:0]   wdata_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_sh_d   = addr_sh_q;
    wr_sh_d     = wr_sh_q;
    rd_sh_d     = rd_sh_q;
    rd_d        = rd_q;
    words_d     = words_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    re_dly_d    = reg_re_q;
    miso_d      = miso_q;
    ferr_d      = 1'b0;
    armed_d     = armed_q;
    arm_cnt_d   = arm_cnt_q;
    addr_full   = {addr_sh_q, mosi_s};
    wdata_full  = {wr_sh_q, mosi_s};

    // After reset the CS chain holds its reset value, not the pin. Only
    // once CS has been seen high from real samples is a fall trusted, so a
    // frame interrupted by reset is never picked up half-way.
    if (!cs_lvl) begin
      arm_cnt_d = '0;
    end else if (!armed_q) begin
      if (arm_cnt_q >= 3'(SYNC_STAGES)) armed_d = 1'b1;
      else                              arm_cnt_d = arm_cnt_q + 3'd1;
    end

    // Slave returns read data one cycle after reg_re.
    if (re_dly_q) rd_sh_d = reg_rdata;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        miso_d  = 1'b0;
        words_d = 1'b0;
        if (cs_fall && armed_q) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          addr_sh_d = addr_full[ADDR_W-2:0];
          if (cnt_q == LAST_ADDR) begin
            cnt_d      = '0;
            state_d    = ST_DUMMY;
            rd_d       = addr_full[RD_POS];
            reg_addr_d = addr_full[ADDR_W-2:0];
            reg_re_d   = addr_full[RD_POS];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_DUMMY: begin
        if (sclk_rise) begin
          if (cnt_q == LAST_DUMMY) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_DATA: begin
        // Mode 0: drive the next bit after each fall so it is stable by the rise.
        if (sclk_fall && rd_q) begin
          miso_d  = rd_sh_q[DATA_W-1];
          rd_sh_d = {rd_sh_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          if (!rd_q) wr_sh_d = wdata_full[DATA_W-2:0];
          // Burst writes advance the address at the first bit of the next
          // word so the previous word's strobe still sees its own address.
          if (words_q && (cnt_q == '0) && !rd_q) reg_addr_d = reg_addr_q + ADDR_ONE;
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (!rd_q) begin
              reg_we_d    = 1'b1;
              reg_wdata_d = wdata_full;
            end
`ifdef SPI_REG_BRIDGE_BURST_EN
            words_d = 1'b1;
            // Prefetch the next word now so its MSB is ready by the next fall.
            if (rd_q) begin
              reg_addr_d = reg_addr_q + ADDR_ONE;
              reg_re_d   = 1'b1;
            end
`else
            state_d = ST_HOLD;
            miso_d  = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_HOLD: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // CS high ends any frame; a rise before a word completes is an error.
    if (cs_lvl) begin
      if (cs_rise && ((state_q == ST_ADDR) || (state_q == ST_DUMMY) ||
                      ((state_q == ST_DATA) && !((cnt_q == '0) && words_q))))
        ferr_d = 1'b1;
      state_d  = ST_IDLE;
      cnt_d    = '0;
      miso_d   = 1'b0;
      reg_we_d = 1'b0;
      reg_re_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      words_q     <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      re_dly_q    <= 1'b0;
      miso_q      <= 1'b0;
      ferr_q      <= 1'b0;
      armed_q     <= 1'b0;
      arm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      words_q     <= words_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      re_dly_q    <= re_dly_d;
      miso_q      <= miso_d;
      ferr_q      <= ferr_d;
      armed_q     <= armed_d;
      arm_cnt_q   <= arm_cnt_d;
    end
  end

  // Shift registers carry data only; their contents are qualified by the FSM.
  always_ff @(posedge sys_clk) begin
    addr_sh_q <= addr_sh_d;
    wr_sh_q   <= wr_sh_d;
    rd_sh_q   <= rd_sh_d;
  end

  assign spi_miso  = miso_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: an SPI master task drives two bridge instances
// (default parameters, and ADDR_W=6/DATA_W=32/DUMMY_CYCLES=1) that share
// SCLK/MOSI with separate chip selects. Expected bus strobes are queued when
// a frame is issued and popped by a monitor; read words are compared against
// a memory model kept in the bench.
module tb_spi_reg_bridge;

  localparam int H    = 6;   // sys_clk cycles per SCLK half period
  localparam int TCLK = 10;
  localparam int K_WE = 0, K_RE = 1, K_FE = 2;

`ifdef SPI_REG_BRIDGE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic spi_clk, spi_mosi, cs0_n, cs1_n, miso0, miso1;
  logic [6:0]  addr0;  logic [15:0] wdata0, rdata0; logic we0, re0, fe0;
  logic [4:0]  addr1;  logic [31:0] wdata1, rdata1; logic we1, re1, fe1;

  spi_reg_bridge dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_clk(spi_clk), .spi_cs_n(cs0_n),
    .spi_mosi(spi_mosi), .spi_miso(miso0), .reg_addr(addr0), .reg_wdata(wdata0),
    .reg_we(we0), .reg_re(re0), .reg_rdata(rdata0), .frame_err(fe0)
  );

  spi_reg_bridge #(.ADDR_W(6), .DATA_W(32), .DUMMY_CYCLES(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_clk(spi_clk), .spi_cs_n(cs1_n),
    .spi_mosi(spi_mosi), .spi_miso(miso1), .reg_addr(addr1), .reg_wdata(wdata1),
    .reg_we(we1), .reg_re(re1), .reg_rdata(rdata1), .frame_err(fe1)
  );

  // Register slaves: store writes, answer reads one cycle later, garbage otherwise.
  logic [15:0] smem0 [128];
  logic [31:0] smem1 [32];
  always @(posedge sys_clk) begin
    if (we0) smem0[addr0] <= wdata0;
    rdata0 <= re0 ? smem0[addr0] : 16'($urandom);
    if (we1) smem1[addr1] <= wdata1;
    rdata1 <= re1 ? smem1[addr1] : $urandom;
  end

  // Reference memory contents, updated when a write frame is issued.
  logic [31:0] mm0 [128];
  logic [31:0] mm1 [32];

  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; } ev_t;
  ev_t q0[$];
  ev_t q1[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wbuf [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic check_ev(input int sel, input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    bit  have;
    vectors++;
    have = 1'b0;
    if (sel == 0) begin if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end end
    else          begin if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end end
    if (!have) begin
      miscompares++;
      $display("FAIL dut%0d strobe: unexpected kind %0d addr %h data %h", sel, k, a, d);
    end else if (e.kind != k || e.addr !== a || e.data !== d) begin
      miscompares++;
      $display("FAIL dut%0d strobe: got kind %0d addr %h data %h, expected kind %0d addr %h data %h",
               sel, k, a, d, e.kind, e.addr, e.data);
    end
  endtask

  task automatic mon_one(input int sel, input logic we, input logic re, input logic fe,
                         input logic [31:0] a, input logic [31:0] d);
    if (we) check_ev(sel, K_WE, a, d);
    if (re) check_ev(sel, K_RE, a, 32'h0);
    if (fe) check_ev(sel, K_FE, 32'h0, 32'h0);
  endtask

  always @(negedge sys_clk) begin
    mon_one(0, we0, re0, fe0, 32'(addr0), 32'(wdata0));
    mon_one(1, we1, re1, fe1, 32'(addr1), wdata1);
  end

  task automatic sclk_bit(input logic mo, input int sel, output logic mi);
    spi_mosi = mo;
    #(H*TCLK);
    spi_clk = 1'b1;
    mi = (sel != 0) ? miso1 : miso0;
    #(H*TCLK);
    spi_clk = 1'b0;
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel != 0) cs1_n = v; else cs0_n = v;
  endtask

  // One SPI frame. part>0 raises CS after that many data bits of the first
  // word; rst_dummy pulses sys_rst in the dummy phase (write frames only).
  task automatic frame(input int sel, input bit rd, input int addr, input int nw,
                       input int part, input bit rst_dummy);
    int aw, dw, dc, size, nb, nwe;
    logic [31:0] dmask, aword, rword, exp_rd [4];
    logic mi;
    aw    = (sel != 0) ? 6 : 8;
    dw    = (sel != 0) ? 32 : 16;
    dc    = (sel != 0) ? 1 : 8;
    size  = 1 << (aw - 1);
    dmask = (sel != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    nwe   = BURST ? nw : 1;

    if (part > 0) begin
      push(sel, K_FE, 32'h0, 32'h0);
    end else if (rst_dummy) begin
      // aborted write: no strobes at all
    end else if (!rd) begin
      for (int i = 0; i < nwe; i++) begin
        push(sel, K_WE, 32'((addr + i) % size), wbuf[i] & dmask);
        if (sel != 0) mm1[(addr + i) % size] = wbuf[i] & dmask;
        else          mm0[(addr + i) % size] = wbuf[i] & dmask;
      end
    end else begin
      push(sel, K_RE, 32'(addr % size), 32'h0);
      if (BURST) for (int i = 1; i <= nw; i++) push(sel, K_RE, 32'((addr + i) % size), 32'h0);
      for (int i = 0; i < nw; i++) begin
        if (i >= nwe) exp_rd[i] = 32'h0;
        else if (sel != 0) exp_rd[i] = mm1[(addr + i) % size];
        else exp_rd[i] = mm0[(addr + i) % size];
      end
    end

    set_cs(sel, 1'b0);
    #(H*TCLK);
    aword = (32'(rd) << (aw - 1)) | 32'(addr % size);
    for (int i = aw - 1; i >= 0; i--) sclk_bit(aword[i], sel, mi);
    for (int i = 0; i < dc; i++) begin
      if (rst_dummy && i == 2) begin
        @(posedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst addr", 32'(addr0), 32'h0);
        chk("rst wdata", 32'(wdata0), 32'h0);
        chk("rst strobes", {29'h0, we0, re0, fe0}, 32'h0);
        chk("rst miso", 32'(miso0), 32'h0);
        sys_rst = 1'b0;
      end
      sclk_bit(1'($urandom), sel, mi);
    end
    for (int w = 0; w < nw; w++) begin
      rword = 32'h0;
      nb = (part > 0) ? part : dw;
      for (int b = dw - 1; b >= dw - nb; b--) begin
        sclk_bit(rd ? 1'($urandom) : wbuf[w][b], sel, mi);
        rword[b] = mi;
      end
      if (rd && part == 0 && !rst_dummy)
        chk($sformatf("dut%0d read @%0h word %0d", sel, addr, w), rword & dmask, exp_rd[w] & dmask);
      if (part > 0) break;
    end
    #(H*TCLK);
    set_cs(sel, 1'b1);
    #(4*H*TCLK);
  endtask

  task automatic wr1(input int sel, input int addr, input logic [31:0] d);
    wbuf[0] = d;
    frame(sel, 1'b0, addr, 1, 0, 1'b0);
  endtask

  task automatic rd1(input int sel, input int addr);
    frame(sel, 1'b1, addr, 1, 0, 1'b0);
  endtask

  logic [15:0] pat [7];

  initial begin
    for (int i = 0; i < 128; i++) begin smem0[i] = 16'h0; mm0[i] = 32'h0; end
    for (int i = 0; i < 32; i++)  begin smem1[i] = 32'h0; mm1[i] = 32'h0; end
    sys_rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("reset addr0", 32'(addr0), 32'h0);
    chk("reset wdata0", 32'(wdata0), 32'h0);
    chk("reset strobes0", {29'h0, we0, re0, fe0}, 32'h0);
    chk("reset miso0", 32'(miso0), 32'h0);
    chk("reset addr1/wdata1", {27'(addr1), 5'h0} | wdata1, 32'h0);
    sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);
    #3;

    // Fixed write patterns at address 0, each read back.
    pat[0] = 16'hAAAA; pat[1] = 16'h5555; pat[2] = 16'h0000; pat[3] = 16'h0001;
    pat[4] = 16'h8000; pat[5] = 16'hFFFF; pat[6] = 16'h2A2A;
    for (int i = 0; i < 7; i++) begin
      wr1(0, 0, 32'(pat[i]));
      rd1(0, 0);
    end

    // Read of 0x86 (flag + address 0x06).
    wr1(0, 6, 32'hAA55);
    rd1(0, 6);

    // CS raised after 5 data bits, then a normal frame.
    wbuf[0] = 32'h1234;
    frame(0, 1'b0, 7, 1, 5, 1'b0);
    wr1(0, 7, 32'h0F0F);
    rd1(0, 7);

    // Multi-word write frame starting at the top address.
    wbuf[0] = 32'h1111; wbuf[1] = 32'h2222; wbuf[2] = 32'h3333;
    frame(0, 1'b0, 7'h7F, 3, 0, 1'b0);
    rd1(0, 7'h7F);
    rd1(0, 0);
    rd1(0, 1);
    frame(0, 1'b1, 7'h7F, 3, 0, 1'b0);

    // Reset during the dummy phase, then a normal frame.
    wbuf[0] = 32'hBEEF;
    frame(0, 1'b0, 7'h15, 1, 0, 1'b1);
    wr1(0, 7'h15, 32'hC0DE);
    rd1(0, 7'h15);

    // Wide configuration.
    wr1(1, 5'h1F, 32'hDEADBEEF);
    rd1(1, 5'h1F);

    // Randomised traffic on both instances.
    for (int i = 0; i < 24; i++) begin
      int sel, nw, a;
      bit rdf;
      sel = (i % 3 == 2) ? 1 : 0;
      rdf = 1'($urandom);
      nw  = int'($urandom_range(1, 2));
      a   = int'($urandom_range(0, (sel != 0) ? 31 : 127));
      for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
      frame(sel, rdf, a, nw, 0, 1'b0);
    end

    repeat (20) @(posedge sys_clk);
    #1;
    chk("dut0 pending strobes", 32'(q0.size()), 32'h0);
    chk("dut1 pending strobes", 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
